// File: rtl/vga_dither_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_dither_out
// Brief    : Aligns sync/blanking with the pipelined pixel, applies a 4x4
//            ordered dither down to 2-bit RGB and drives the TinyVGA PMOD bus.
// Revision : 1.0  initial release
// ============================================================================
module vga_dither_out #(
    parameter int PIPE_DELAY = 2,
    parameter bit TEMPORAL   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       display_on_i,
    input  logic [9:0] hpos_i,
    input  logic [9:0] vpos_i,
    input  logic [7:0] pix_i,
    output logic [7:0] uo_out,
    output logic [1:0] frame_cnt
);

    localparam int c_TAP_W = 7;

    logic [c_TAP_W-1:0] w_tap_in;
    logic [c_TAP_W-1:0] w_tap_d;
    logic               w_hsync_d;
    logic               w_vsync_d;
    logic               w_display_on_d;
    logic [1:0]         w_hpos_d;
    logic [1:0]         w_vpos_d;
    logic [1:0]         w_x;
    logic [3:0]         w_thresh;
    logic [1:0]         w_r_q;
    logic [1:0]         w_g_q;
    logic [1:0]         w_b_q;
    logic               w_unused;

    logic [7:0]         r_uo_out;
    logic [1:0]         r_frame_cnt;
    logic               r_vsync_prev;
    logic               r_edge_armed;

    assign w_tap_in = {hsync_i, vsync_i, display_on_i, hpos_i[1:0], vpos_i[1:0]};
    assign w_unused = &{1'b0, hpos_i[9:2], vpos_i[9:2], pix_i[1:0]};

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign w_tap_d = w_tap_in;
        end else begin : g_delay
            logic [c_TAP_W-1:0] r_pipe [PIPE_DELAY];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_tap_in;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_tap_d = r_pipe[PIPE_DELAY-1];
        end
    endgenerate

    assign {w_hsync_d, w_vsync_d, w_display_on_d, w_hpos_d, w_vpos_d} = w_tap_d;

    function automatic logic [3:0] f_bayer(input logic [1:0] y, input logic [1:0] x);
        logic [3:0] v;
        case ({y, x})
            4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
            4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
            4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'hA: v = 4'd1;   4'hB: v = 4'd9;
            4'hC: v = 4'd15;  4'hD: v = 4'd7;   4'hE: v = 4'd13;  default: v = 4'd5;
        endcase
        return v;
    endfunction

    // Round up when the two fractional bits (scaled to 0..12) exceed the threshold.
    function automatic logic [1:0] f_quant(input logic [3:0] c, input logic [3:0] thresh);
        logic [2:0] q;
        q = {1'b0, c[3:2]} + {2'b00, ({c[1:0], 2'b00} > thresh)};
        return (q > 3'd3) ? 2'd3 : q[1:0];
    endfunction

    assign w_x      = w_hpos_d + (TEMPORAL ? r_frame_cnt : 2'd0);
    assign w_thresh = f_bayer(w_vpos_d, w_x);
    assign w_r_q    = w_display_on_d ? f_quant(pix_i[7:4], w_thresh) : 2'b00;
    assign w_g_q    = w_display_on_d ? f_quant(pix_i[6:3], w_thresh) : 2'b00;
    assign w_b_q    = w_display_on_d ? f_quant(pix_i[5:2], w_thresh) : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_uo_out <= 8'h00;
        end else begin
            r_uo_out <= {w_hsync_d, w_b_q[0], w_g_q[0], w_r_q[0],
                         w_vsync_d, w_b_q[1], w_g_q[1], w_r_q[1]};
        end
    end

    // The armed flag discards the first edge after reset, whose "previous"
    // vsync value is only the reset value rather than an observed one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_prev <= 1'b0;
            r_edge_armed <= 1'b0;
            r_frame_cnt  <= 2'd0;
        end else begin
            r_vsync_prev <= w_vsync_d;
            r_edge_armed <= 1'b1;
            if (r_edge_armed && w_vsync_d && !r_vsync_prev) begin
                r_frame_cnt <= r_frame_cnt + 2'd1;
            end
        end
    end

    assign uo_out    = r_uo_out;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_dither_out.sv
`default_nettype none
// Bench for vga_dither_out: five parameterisations share one stimulus stream,
// checked each cycle against a behavioural model plus hand-computed literals.
module tb_vga_dither_out;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic hs = 1'b0, vs = 1'b0, de = 1'b0;
    logic [9:0] hp = '0, vp = '0;
    logic [7:0] pix = '0;
    logic [NI-1:0][7:0] uo;
    logic [NI-1:0][1:0] fc;

    int errors = 0;
    int checks = 0;
    int n = 0;
    int fc_m [NI];
    int bay [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    int rexp [4] = '{2, 1, 2, 1};

    bit         hs_h  [0:8191];
    bit         vs_h  [0:8191];
    bit         de_h  [0:8191];
    logic [1:0] hp_h  [0:8191];
    logic [1:0] vp_h  [0:8191];
    logic [7:0] pix_h [0:8191];

    always #5 clk = ~clk;

    vga_dither_out #(.PIPE_DELAY(2), .TEMPORAL(1'b1)) u_d0 (
        .clk(clk), .reset(reset), .hsync_i(hs), .vsync_i(vs), .display_on_i(de),
        .hpos_i(hp), .vpos_i(vp), .pix_i(pix), .uo_out(uo[0]), .frame_cnt(fc[0]));
    vga_dither_out #(.PIPE_DELAY(2), .TEMPORAL(1'b0)) u_d1 (
        .clk(clk), .reset(reset), .hsync_i(hs), .vsync_i(vs), .display_on_i(de),
        .hpos_i(hp), .vpos_i(vp), .pix_i(pix), .uo_out(uo[1]), .frame_cnt(fc[1]));
    vga_dither_out #(.PIPE_DELAY(0), .TEMPORAL(1'b1)) u_d2 (
        .clk(clk), .reset(reset), .hsync_i(hs), .vsync_i(vs), .display_on_i(de),
        .hpos_i(hp), .vpos_i(vp), .pix_i(pix), .uo_out(uo[2]), .frame_cnt(fc[2]));
    vga_dither_out #(.PIPE_DELAY(1), .TEMPORAL(1'b1)) u_d3 (
        .clk(clk), .reset(reset), .hsync_i(hs), .vsync_i(vs), .display_on_i(de),
        .hpos_i(hp), .vpos_i(vp), .pix_i(pix), .uo_out(uo[3]), .frame_cnt(fc[3]));
    vga_dither_out #(.PIPE_DELAY(7), .TEMPORAL(1'b1)) u_d4 (
        .clk(clk), .reset(reset), .hsync_i(hs), .vsync_i(vs), .display_on_i(de),
        .hpos_i(hp), .vpos_i(vp), .pix_i(pix), .uo_out(uo[4]), .frame_cnt(fc[4]));

    function automatic int pd_of(int i);
        case (i)
            2:       return 0;
            3:       return 1;
            4:       return 7;
            default: return 2;
        endcase
    endfunction

    function automatic bit tmp_of(int i);
        return (i != 1);
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic int quant(int c, int th);
        int q;
        q = c / 4 + ((((c % 4) * 4) > th) ? 1 : 0);
        return (q > 3) ? 3 : q;
    endfunction

    // vsync as seen after the delay line at edge k (zero before reset release).
    function automatic bit vd(int pd, int k);
        int s;
        s = k - pd;
        return (s >= 1) ? vs_h[s] : 1'b0;
    endfunction

    function automatic logic [7:0] model_uo(int pd, bit tmp, int k, int f);
        int s, x, y, r, g, b;
        bit h, v, d;
        s = k - pd;
        h = 0; v = 0; d = 0; x = 0; y = 0;
        if (s >= 1) begin
            h = hs_h[s]; v = vs_h[s]; d = de_h[s];
            x = int'(hp_h[s]); y = int'(vp_h[s]);
        end
        if (tmp) x = (x + f) % 4;
        r = 0; g = 0; b = 0;
        if (d) begin
            r = quant(int'(pix_h[k][7:4]), bay[y*4 + x]);
            g = quant(int'(pix_h[k][6:3]), bay[y*4 + x]);
            b = quant(int'(pix_h[k][5:2]), bay[y*4 + x]);
        end
        return {h, b[0], g[0], r[0], v, b[1], g[1], r[1]};
    endfunction

    // Record what every DUT samples at each edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                n = 0;
            end else begin
                n = n + 1;
                hs_h[n] = hs; vs_h[n] = vs; de_h[n] = de;
                hp_h[n] = hp[1:0]; vp_h[n] = vp[1:0]; pix_h[n] = pix;
            end
        end
    end

    // Compare process: model versus all instances, once per cycle.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (reset || n == 0) begin
                    fc_m[i] = 0;
                    chk($sformatf("rst_uo_i%0d", i), uo[i], 8'h00);
                    chk($sformatf("rst_fc_i%0d", i), {6'b0, fc[i]}, 8'h00);
                end else begin
                    e = model_uo(pd_of(i), tmp_of(i), n, fc_m[i]);
                    if (n >= 2 && vd(pd_of(i), n) && !vd(pd_of(i), n - 1))
                        fc_m[i] = (fc_m[i] + 1) % 4;
                    chk($sformatf("model_uo_i%0d_n%0d", i, n), uo[i], e);
                    chk($sformatf("model_fc_i%0d_n%0d", i, n), {6'b0, fc[i]}, 8'(fc_m[i]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic drive(bit h, bit v, bit d, int x, int y, logic [7:0] p);
        hs = h; vs = v; de = d; hp = 10'(x); vp = 10'(y); pix = p;
        @(posedge clk);
        #1;
    endtask

    task automatic vpulse();
        repeat (3)  drive(0, 1, 0, 0, 0, 8'h00);
        repeat (10) drive(0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic run_frame(int f);
        bit d;
        logic [7:0] p;
        for (int v = 0; v < 6; v++) begin
            for (int x = 0; x < 12; x++) begin
                d = (x < 8) && (v < 4);
                case (f)
                    0:       p = 8'hFF;
                    1:       p = d ? 8'h00 : 8'hFF;
                    2:       p = 8'h60;
                    default: p = 8'((x * 37 + v * 59 + f * 13) & 255);
                endcase
                drive((x >= 9) && (x < 11), v == 5, d, x % 4 + 4 * (v % 2), v, p);
            end
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_uo", uo[0], 8'h00);
        chk("reset_fc", {6'b0, fc[0]}, 8'h00);
        #2 reset = 1'b0;

        // Full-scale pixel saturates every channel.
        repeat (3) drive(0, 0, 1, 0, 0, 8'hFF);
        chk("t1_white", uo[0] & 8'h77, 8'h77);

        // R=6 on the static instance walks the top Bayer row.
        for (int x = 0; x < 6; x++) begin
            drive(0, 0, 1, x % 4, 0, 8'h60);
            if (x >= 2) chk($sformatf("t3_r_x%0d", x - 2), {6'b0, uo[1][0], uo[1][4]}, 8'(rexp[x-2]));
        end

        // One frame edge shifts the temporal instance to column 1.
        vpulse();
        chk("t4_fc1", {6'b0, fc[0]}, 8'h01);
        repeat (4) drive(0, 0, 1, 0, 0, 8'h60);
        chk("t4_r_temporal", {6'b0, uo[0][0], uo[0][4]}, 8'h01);
        chk("t4_r_static", {6'b0, uo[1][0], uo[1][4]}, 8'h02);
        repeat (3) vpulse();
        chk("t4_fc_wrap", {6'b0, fc[0]}, 8'h00);

        // hsync step latency per pipe depth, with full-scale pixel during blanking.
        repeat (10) drive(0, 0, 0, 0, 0, 8'hFF);
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 0, 0, 8'hFF);
            for (int i = 0; i < NI; i++)
                chk($sformatf("t5_hs_i%0d_k%0d", i, k), {7'b0, uo[i][7]}, (k >= pd_of(i)) ? 8'h01 : 8'h00);
        end
        chk("t2_blank", uo[0] & 8'h77, 8'h00);

        // Asynchronous reset mid-line.
        vpulse();
        repeat (3) drive(0, 0, 1, 0, 0, 8'hFF);
        chk("t6_pre_fc", {6'b0, fc[0]}, 8'h01);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_async_uo", uo[0], 8'h00);
        chk("t6_async_fc", {6'b0, fc[0]}, 8'h00);
        chk("t6_async_uo_pd7", uo[4], 8'h00);
        @(posedge clk);
        #2 reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 1, 0, 0, 8'hFF);
            chk($sformatf("t6_recover_k%0d", k), uo[0], (k == 3) ? 8'h77 : 8'h00);
        end
        chk("t6_post_fc", {6'b0, fc[0]}, 8'h00);

        for (int f = 0; f < 6; f++) run_frame(f);
        repeat (10) drive(0, 0, 0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
